// File: rtl/data_memory_responder.sv
// Single-port word memory answering one store channel and one load channel with fixed latencies.
// Each channel owns one pending slot; stores are serviced before loads to keep program order.
module data_memory_responder #(
    parameter int unsigned MEMORY_SIZE   = 2**14,
    parameter int unsigned LOAD_LATENCY  = 4,
    parameter int unsigned STORE_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_request_i,
    input  logic [31:0] load_address_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    input  logic        store_request_i,
    input  logic [31:0] store_address_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  store_width_i,
    output logic        store_done_o
);

    localparam int unsigned AddrW  = $clog2(MEMORY_SIZE);
    localparam int unsigned Words  = MEMORY_SIZE / 4;
    localparam int unsigned MaxLat = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY
                                                                     : STORE_LATENCY;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] LoadInit  = CntW'(LOAD_LATENCY - 1);
    localparam logic [CntW-1:0] StoreInit = CntW'(STORE_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StStoreWait, StLoadWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic             st_pend_q;
    logic [AddrW-1:0] st_addr_q;
    logic [31:0]      st_data_q;
    logic [1:0]       st_width_q;
    logic             ld_pend_q;
    logic [AddrW-3:0] ld_idx_q;
    logic [31:0]      load_data_q;

    logic st_accept, ld_accept, st_take, ld_take;
    logic done_raw, valid_raw;

    logic [31:0] mem [Words];
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    // Upper address bits wrap away; load byte offset is irrelevant to an aligned word read.
    logic unused_addr;
    assign unused_addr = ^{load_address_i[31:AddrW], load_address_i[1:0],
                           store_address_i[31:AddrW]};

    // A request is dropped while its own slot is pending or its channel is being serviced.
    assign st_accept = store_request_i && !st_pend_q && (state_q != StStoreWait);
    assign ld_accept = load_request_i && !ld_pend_q && (state_q != StLoadWait);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_take   = 1'b0;
        ld_take   = 1'b0;
        done_raw  = 1'b0;
        valid_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (st_pend_q) begin
                    state_d = StStoreWait;
                    cnt_d   = StoreInit;
                    st_take = 1'b1;
                end else if (ld_pend_q) begin
                    state_d = StLoadWait;
                    cnt_d   = LoadInit;
                    ld_take = 1'b1;
                end
            end
            StStoreWait: begin
                if (cnt_q == '0) begin
                    done_raw = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLoadWait: begin
                if (cnt_q == '0) begin
                    valid_raw = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset in the final wait cycle must suppress both the pulse and the write.
    assign store_done_o = done_raw && !rst_i;
    assign load_valid_o = valid_raw && !rst_i;

    assign rd_data     = mem[ld_idx_q];
    assign load_data_o = load_valid_o ? rd_data : load_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            st_pend_q   <= 1'b0;
            ld_pend_q   <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (st_accept) begin
                st_pend_q  <= 1'b1;
                st_addr_q  <= store_address_i[AddrW-1:0];
                st_data_q  <= store_data_i;
                st_width_q <= store_width_i;
            end else if (st_take) begin
                st_pend_q <= 1'b0;
            end
            if (ld_accept) begin
                ld_pend_q <= 1'b1;
                ld_idx_q  <= load_address_i[AddrW-1:2];
            end else if (ld_take) begin
                ld_pend_q <= 1'b0;
            end
            if (load_valid_o) begin
                load_data_q <= rd_data;
            end
        end
    end

    // Narrow stores replicate the payload across lanes and enable only the addressed ones.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = st_data_q;
        unique case (st_width_q)
            2'd0: begin
                wr_be   = 4'b0001 << st_addr_q[1:0];
                wr_data = {4{st_data_q[7:0]}};
            end
            2'd1: begin
                wr_be   = st_addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{st_data_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = st_data_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (store_done_o) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[st_addr_q[AddrW-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule
